// File: rtl/run_len_pkg.sv
// Shared types and constants for the windowed run-length scheduler.
package run_len_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int unsigned DEF_LEN_A = 2;
  localparam int unsigned DEF_LEN_B = 4;

  // All-ones value of a counter of the given width.
  function automatic int unsigned sat_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  localparam int unsigned RUN_MAX_DEF = sat_max(3);
  localparam int unsigned CNT_MAX_DEF = sat_max(8);

endpackage

// File: rtl/run_len_sched_if.sv
// Host/serial-side bundle for run_len_sched: config, start, bit stream and report.
interface run_len_sched_if #(
  parameter int CW   = 3,
  parameter int CNTW = 8
);
  logic            cfg_we;
  logic [CW-1:0]   cfg_len_a;
  logic [CW-1:0]   cfg_len_b;
  logic            start;
  logic            input_valid;
  logic            input_bit;
  logic            busy;
  logic            match_pulse;
  logic            report_valid;
  logic [CNTW-1:0] report_count;
  logic            report_ready;
  logic            run_sat;

  modport master (
    output cfg_we, cfg_len_a, cfg_len_b, start, input_valid, input_bit, report_ready,
    input  busy, match_pulse, report_valid, report_count, run_sat
  );

  modport slave (
    input  cfg_we, cfg_len_a, cfg_len_b, start, input_valid, input_bit, report_ready,
    output busy, match_pulse, report_valid, report_count, run_sat
  );
endinterface

// File: rtl/run_len_detect.sv
// Saturating run-of-ones counter with a dual target-length compare on the terminating 0.
module run_len_detect
  import run_len_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          bit_i,
  input  logic          valid_i,
  input  logic          clear_i,
  input  logic [CW-1:0] len_a_i,
  input  logic [CW-1:0] len_b_i,
  output logic          match_o,
  output logic          sat_o
);

  localparam logic [CW-1:0] RUN_MAX = CW'(sat_max(CW));
  localparam logic [CW-1:0] RUN_PRE = CW'(sat_max(CW) - 1);

  logic [CW-1:0] run_q, run_d;

  always_comb begin
    run_d   = run_q;
    match_o = 1'b0;
    sat_o   = 1'b0;
    if (clear_i) begin
      run_d = '0;
    end else if (valid_i) begin
      if (bit_i) begin
        if (run_q != RUN_MAX) run_d = run_q + CW'(1);
        sat_o = (run_q >= RUN_PRE);
      end else begin
        // A zero target never matches because an empty run is excluded first.
        match_o = (run_q != '0) && ((run_q == len_a_i) || (run_q == len_b_i));
        run_d   = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) run_q <= '0;
    else       run_q <= run_d;
  end

endmodule

// File: rtl/run_len_sched.sv
// Window sequencer: config latch, bit-position counter, match tally and report handshake.
//   state  | meaning
//   IDLE   | accepts config writes and start; report_count holds the last tally
//   RUN    | consumes WINDOW valid bits, tallying runs that hit len_a or len_b
//   REPORT | report_valid high with a stable tally until report_ready
module run_len_sched
  import run_len_pkg::*;
#(
  parameter int CW     = 3,
  parameter int CNTW   = 8,
  parameter int WINDOW = 16,
  parameter int WW     = 5
) (
  input logic            clock,
  input logic            reset,
  run_len_sched_if.slave bus
);

  localparam logic [WW-1:0]   LAST_POS = WW'(WINDOW - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(sat_max(CNTW));

  state_t          state_q, state_d;
  logic [CW-1:0]   len_a_q, len_a_d;
  logic [CW-1:0]   len_b_q, len_b_d;
  logic [WW-1:0]   bitpos_q, bitpos_d;
  logic [CNTW-1:0] tally_q, tally_d;
  logic            run_sat_q, run_sat_d;
  logic            match_pulse_q;

  logic det_valid, det_clear, det_match, det_sat;

  assign det_valid = (state_q == RUN) && bus.input_valid;
  // Holding the counter clear outside RUN discards any run left open at window end.
  assign det_clear = (state_q != RUN);

  run_len_detect #(.CW(CW)) u_detect (
    .clock   (clock),
    .reset   (reset),
    .bit_i   (bus.input_bit),
    .valid_i (det_valid),
    .clear_i (det_clear),
    .len_a_i (len_a_q),
    .len_b_i (len_b_q),
    .match_o (det_match),
    .sat_o   (det_sat)
  );

  always_comb begin
    state_d   = state_q;
    len_a_d   = len_a_q;
    len_b_d   = len_b_q;
    bitpos_d  = bitpos_q;
    tally_d   = tally_q;
    run_sat_d = run_sat_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cfg_we) begin
          len_a_d = bus.cfg_len_a;
          len_b_d = bus.cfg_len_b;
        end
        if (bus.start) begin
          state_d   = RUN;
          bitpos_d  = '0;
          tally_d   = '0;
          run_sat_d = 1'b0;
        end
      end
      RUN: begin
        if (det_sat) run_sat_d = 1'b1;
        if (det_match && (tally_q != CNT_MAX)) tally_d = tally_q + CNTW'(1);
        if (bus.input_valid) begin
          if (bitpos_q == LAST_POS) state_d = REPORT;
          else                      bitpos_d = bitpos_q + WW'(1);
        end
      end
      REPORT: begin
        if (bus.report_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      len_a_q       <= CW'(DEF_LEN_A);
      len_b_q       <= CW'(DEF_LEN_B);
      bitpos_q      <= '0;
      tally_q       <= '0;
      run_sat_q     <= 1'b0;
      match_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_a_q       <= len_a_d;
      len_b_q       <= len_b_d;
      bitpos_q      <= bitpos_d;
      tally_q       <= tally_d;
      run_sat_q     <= run_sat_d;
      match_pulse_q <= det_match;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.report_valid = (state_q == REPORT);
  assign bus.report_count = tally_q;
  assign bus.match_pulse  = match_pulse_q;
  assign bus.run_sat      = run_sat_q;

endmodule

// File: tb/tb_run_len_sched.sv
// Self-checking bench for run_len_sched against a run-list reference model.
module tb_run_len_sched;

  localparam int CW     = 3;
  localparam int CNTW   = 8;
  localparam int WINDOW = 16;
  localparam int WW     = 5;
  localparam int RMAX   = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  run_len_sched_if #(.CW(CW), .CNTW(CNTW)) bus ();

  run_len_sched #(.CW(CW), .CNTW(CNTW), .WINDOW(WINDOW), .WW(WW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  int model_a = 2;
  int model_b = 4;
  int bits_q[$];
  int gaps_q[$];
  bit exp_match[$];
  int exp_tally;
  bit exp_sat;
  bit junk_cfg = 1'b0;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    bus.cfg_we       = 1'b0;
    bus.cfg_len_a    = '0;
    bus.cfg_len_b    = '0;
    bus.start        = 1'b0;
    bus.input_valid  = 1'b0;
    bus.input_bit    = 1'b0;
    bus.report_ready = 1'b0;
  endtask

  task automatic apply_junk;
    if (junk_cfg) begin
      bus.cfg_we    = 1'b1;
      bus.cfg_len_a = CW'(5);
      bus.cfg_len_b = CW'(5);
      bus.start     = 1'b1;
    end
  endtask

  // Reference: split the window into runs of ones; a run counts when a 0 closes it
  // and its length (capped at the counter maximum) equals a nonzero target.
  task automatic build_model;
    int run;
    int eff;
    bit m;
    exp_match.delete();
    exp_tally = 0;
    exp_sat   = 1'b0;
    run       = 0;
    foreach (bits_q[i]) begin
      if (bits_q[i] != 0) begin
        run++;
        if (run >= RMAX) exp_sat = 1'b1;
        exp_match.push_back(1'b0);
      end else begin
        eff = (run > RMAX) ? RMAX : run;
        m = (eff != 0) && ((eff == model_a) || (eff == model_b));
        exp_match.push_back(m);
        if (m) exp_tally++;
        run = 0;
      end
    end
  endtask

  task automatic load_bits(input logic [15:0] pattern);
    bits_q.delete();
    gaps_q.delete();
    for (int i = 15; i >= 0; i--) begin
      bits_q.push_back(int'(pattern[i]));
      gaps_q.push_back(0);
    end
  endtask

  task automatic write_cfg(input int a, input int b);
    bus.cfg_we    = 1'b1;
    bus.cfg_len_a = CW'(a);
    bus.cfg_len_b = CW'(b);
    tick();
    bus.cfg_we    = 1'b0;
    model_a = a;
    model_b = b;
  endtask

  task automatic run_window;
    build_model();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %0b want 1", bus.busy);
    end
    foreach (bits_q[i]) begin
      for (int g = 0; g < gaps_q[i]; g++) begin
        apply_junk();
        bus.input_valid = 1'b0;
        bus.input_bit   = 1'($urandom_range(0, 1));
        tick();
        checks++;
        if (bus.match_pulse !== 1'b0 || bus.report_valid !== 1'b0) begin
          errors++;
          $display("FAIL gap_cycle bit %0d: got mp=%0b rv=%0b want 0 0", i + 1, bus.match_pulse, bus.report_valid);
        end
      end
      apply_junk();
      bus.input_valid = 1'b1;
      bus.input_bit   = 1'(bits_q[i]);
      tick();
      bus.input_valid = 1'b0;
      checks++;
      if (bus.match_pulse !== exp_match[i]) begin
        errors++;
        $display("FAIL match_pulse bit %0d: got %0b want %0b", i + 1, bus.match_pulse, exp_match[i]);
      end
      checks++;
      if (bus.report_valid !== (i == bits_q.size() - 1)) begin
        errors++;
        $display("FAIL report_valid_timing bit %0d: got %0b want %0b", i + 1, bus.report_valid, (i == bits_q.size() - 1));
      end
    end
    checks++;
    if (bus.report_count !== CNTW'(exp_tally)) begin
      errors++;
      $display("FAIL report_count: got %0d want %0d", bus.report_count, exp_tally);
    end
    checks++;
    if (bus.run_sat !== exp_sat) begin
      errors++;
      $display("FAIL run_sat: got %0b want %0b", bus.run_sat, exp_sat);
    end
  endtask

  task automatic handshake(input int delay);
    for (int d = 0; d < delay; d++) begin
      apply_junk();
      bus.report_ready = 1'b0;
      tick();
      checks++;
      if (bus.report_valid !== 1'b1 || bus.report_count !== CNTW'(exp_tally)) begin
        errors++;
        $display("FAIL report_hold cycle %0d: got rv=%0b cnt=%0d want 1 %0d", d, bus.report_valid, bus.report_count, exp_tally);
      end
    end
    bus.report_ready = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (bus.report_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL handshake_idle: got rv=%0b busy=%0b want 0 0", bus.report_valid, bus.busy);
    end
    tick();
    checks++;
    if (bus.report_count !== CNTW'(exp_tally) || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL count_held_idle: got cnt=%0d busy=%0b want %0d 0", bus.report_count, bus.busy, exp_tally);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (bus.busy !== 1'b0 || bus.match_pulse !== 1'b0 || bus.report_valid !== 1'b0 ||
        bus.report_count !== '0 || bus.run_sat !== 1'b0) begin
      errors++;
      $display("FAIL %s: got busy=%0b mp=%0b rv=%0b cnt=%0d sat=%0b want all 0", tag,
               bus.busy, bus.match_pulse, bus.report_valid, bus.report_count, bus.run_sat);
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_a = 2;
    model_b = 4;
    check_reset_outputs("reset_state");
  endtask

  task automatic test_default_stream;
    load_bits(16'b1101_1110_1110_0110);
    run_window();
    checks++;
    if (bus.report_count !== 8'd3) begin
      errors++;
      $display("FAIL default_count: got %0d want 3", bus.report_count);
    end
    handshake(0);
  endtask

  task automatic test_cfg_len3_0;
    write_cfg(3, 0);
    load_bits(16'b1101_1110_1110_0110);
    run_window();
    checks++;
    if (bus.report_count !== 8'd1) begin
      errors++;
      $display("FAIL cfg3_0_count: got %0d want 1", bus.report_count);
    end
    handshake(2);
  endtask

  task automatic test_saturation;
    write_cfg(7, 0);
    load_bits(16'b1111_1111_1000_0000);
    run_window();
    checks++;
    if (bus.run_sat !== 1'b1 || bus.report_count !== 8'd1) begin
      errors++;
      $display("FAIL saturation: got sat=%0b cnt=%0d want 1 1", bus.run_sat, bus.report_count);
    end
    handshake(1);
  endtask

  task automatic test_backpressure;
    write_cfg(2, 4);
    load_bits(16'b1111_1011_0111_1000);
    junk_cfg = 1'b1;
    run_window();
    handshake(5);
    junk_cfg = 1'b0;
    load_bits(16'b1111_1011_0111_1000);
    run_window();
    checks++;
    if (bus.report_count !== 8'd2) begin
      errors++;
      $display("FAIL lengths_kept_2_4: got %0d want 2", bus.report_count);
    end
    handshake(0);
  endtask

  task automatic test_gaps_open_run;
    load_bits(16'b1100_0000_0000_0011);
    gaps_q[1]  = 3;
    gaps_q[15] = 2;
    run_window();
    checks++;
    if (bus.report_count !== 8'd1) begin
      errors++;
      $display("FAIL gapped_open_run: got %0d want 1", bus.report_count);
    end
    handshake(1);
  endtask

  task automatic test_reset_mid_run;
    write_cfg(3, 5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.input_valid = 1'b1;
      bus.input_bit   = (i >= 5);
      tick();
    end
    bus.input_valid = 1'b1;
    bus.input_bit   = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    model_a = 2;
    model_b = 4;
    check_reset_outputs("reset_mid_run");
    load_bits(16'b1101_1110_1110_0110);
    run_window();
    handshake(0);
  endtask

  task automatic test_random;
    for (int w = 0; w < 24; w++) begin
      write_cfg(int'($urandom_range(0, RMAX)), int'($urandom_range(0, RMAX)));
      bits_q.delete();
      gaps_q.delete();
      for (int i = 0; i < WINDOW; i++) begin
        bits_q.push_back(($urandom_range(0, 3) != 0) ? 1 : 0);
        gaps_q.push_back(($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0);
      end
      run_window();
      handshake(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_default_stream();
    test_cfg_len3_0();
    test_saturation();
    test_backpressure();
    test_gaps_open_run();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
